// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - elastic valid/ready pipeline-stage buffer with flush
//
// Purpose
//   DEPTH-entry FIFO sitting on one pipeline stage boundary. It carries an
//   opaque WIDTH-bit payload unchanged and in order. Downstream stalls the
//   stage by deasserting out_ready. flush squashes every held entry for
//   branch/jump recovery.
//
// Optional feature
//   PIPE_STAGE_PERF_EN adds the saturating stall_cycles/bubble_cycles
//   counters and their ports. The default build has neither.
//
// Ports
//   clk            in   1      rising-edge clock
//   reset          in   1      asynchronous, active-high reset
//   flush          in   1      synchronous squash of all held entries
//   in_valid       in   1      upstream payload valid
//   in_ready       out  1      buffer can accept this cycle (registered state only)
//   in_data        in   WIDTH  upstream payload
//   out_valid      out  1      head entry valid
//   out_ready      in   1      downstream accepts head this cycle
//   out_data       out  WIDTH  head payload, zero when out_valid=0
//   count          out  CW     entries held, CW=$clog2(DEPTH+1)
//   stall_cycles   out  CNT_W  [PIPE_STAGE_PERF_EN] cycles with in_valid & !in_ready
//   bubble_cycles  out  CNT_W  [PIPE_STAGE_PERF_EN] cycles with out_ready & !out_valid

module pipe_stage_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef PIPE_STAGE_PERF_EN
    output logic [CW-1:0]    count,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_cycles
`else
    output logic [CW-1:0]    count
`endif
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    generate
        if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
            $error("pipe_stage_buf: DEPTH must be in 1..8");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("pipe_stage_buf: CNT_W must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    // Low while reset is high. Set on the first edge after release, so that
    // in_ready rises one cycle after release and depends on no combinational
    // path from reset.
    logic             live;
    logic             push;
    logic             pop;

    // Explicit wrap compare keeps non-power-of-2 depths legal.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = live && (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign count     = count_q;

    // flush overrides both handshakes. The same-cycle input is dropped, and
    // the head is discarded rather than delivered.
    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live    <= 1'b0;
            count_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else begin
            live <= 1'b1;
            if (flush) begin
                count_q <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= next_ptr(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= next_ptr(rd_ptr);
                end
                if (push && !pop) begin
                    count_q <= count_q + 1'b1;
                end else if (pop && !push) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    // Payload storage needs no reset. out_data is masked by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    // Saturating counters. Only reset clears them. Flush cycles are not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles  <= '0;
            bubble_cycles <= '0;
        end else if (!flush) begin
            if (in_valid && !in_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (out_ready && !out_valid && (bubble_cycles != '1)) begin
                bubble_cycles <= bubble_cycles + 1'b1;
            end
        end
    end
`endif

    // Upstream must hold a refused payload steady until it is taken.
    property p_hold_stalled_data;
        @(posedge clk) disable iff (reset)
            (in_valid && !in_ready && !flush) |=> (!in_valid || $stable(in_data));
    endproperty
    a_hold_stalled_data: assert property (p_hold_stalled_data);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - queue-model bench for pipe_stage_buf at DEPTH=2 and DEPTH=3
module tb_pipe_stage_buf;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;

    logic        d_in_ready  [2];
    logic        d_out_valid [2];
    logic [15:0] d_out_data  [2];
    logic [1:0]  d_count     [2];
`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] st0, bu0;
    logic [3:0]  st1, bu1;
`endif

    pipe_stage_buf #(.WIDTH(16), .DEPTH(2), .CNT_W(16)) u_d2 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(d_in_ready[0]), .in_data(in_data),
        .out_valid(d_out_valid[0]), .out_ready(out_ready), .out_data(d_out_data[0]),
`ifdef PIPE_STAGE_PERF_EN
        .count(d_count[0]), .stall_cycles(st0), .bubble_cycles(bu0)
`else
        .count(d_count[0])
`endif
    );

    pipe_stage_buf #(.WIDTH(16), .DEPTH(3), .CNT_W(4)) u_d3 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(d_in_ready[1]), .in_data(in_data),
        .out_valid(d_out_valid[1]), .out_ready(out_ready), .out_data(d_out_data[1]),
`ifdef PIPE_STAGE_PERF_EN
        .count(d_count[1]), .stall_cycles(st1), .bubble_cycles(bu1)
`else
        .count(d_count[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d got %0h exp %0h", nm, k, act, exp);
        end
    endtask

    // Reference model: one FIFO queue per instance, plus a flag for "first
    // edge after reset seen".
    logic [15:0] mq [2][$];
    bit          m_live = 1'b0;
    int          m_stall  [2] = '{0, 0};
    int          m_bubble [2] = '{0, 0};
    bit          prev_stalled = 1'b0;
    bit          r_s [2];
    bit          v_s [2];

    function automatic int depth_of(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    function automatic int smax(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic bit exp_rdy(input int k);
        return m_live && (mq[k].size() < depth_of(k));
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            r_s[k] = exp_rdy(k);
            v_s[k] = (mq[k].size() != 0);
        end
        prev_stalled = !reset && in_valid && !flush && (!r_s[0] || !r_s[1]);
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                m_stall[k]  = 0;
                m_bubble[k] = 0;
            end
            m_live = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!flush) begin
                    if (in_valid && !r_s[k] && m_stall[k] < smax(k)) m_stall[k]++;
                    if (out_ready && !v_s[k] && m_bubble[k] < smax(k)) m_bubble[k]++;
                end
                if (flush) begin
                    mq[k].delete();
                end else begin
                    if (v_s[k] && out_ready) void'(mq[k].pop_front());
                    if (in_valid && r_s[k]) mq[k].push_back(in_data);
                end
            end
            m_live = 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("in_ready",  k, 32'(d_in_ready[k]),  32'(exp_rdy(k)));
            chk("out_valid", k, 32'(d_out_valid[k]), 32'(mq[k].size() != 0));
            chk("out_data",  k, 32'(d_out_data[k]),  (mq[k].size() != 0) ? 32'(mq[k][0]) : 32'd0);
            chk("count",     k, 32'(d_count[k]),     32'(mq[k].size()));
        end
`ifdef PIPE_STAGE_PERF_EN
        chk("stall_cycles",  0, 32'(st0), 32'(m_stall[0]));
        chk("bubble_cycles", 0, 32'(bu0), 32'(m_bubble[0]));
        chk("stall_cycles",  1, 32'(st1), 32'(m_stall[1]));
        chk("bubble_cycles", 1, 32'(bu1), 32'(m_bubble[1]));
`endif
    end

    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        next();
        next();
        reset = 1'b0;
        next();
    endtask

    logic [15:0] t2_vals [3];
    int          pct;

    initial begin
        reset = 1'b1;
        idle_inputs();
        next();
        next();
        // Reset state and release
        chk("t1_out_valid", 0, 32'(d_out_valid[0]), 32'd0);
        chk("t1_out_data",  0, 32'(d_out_data[0]),  32'd0);
        chk("t1_in_ready",  0, 32'(d_in_ready[0]),  32'd0);
        chk("t1_count",     0, 32'(d_count[0]),     32'd0);
        reset = 1'b0;
        next();
        chk("t1_in_ready_rel", 0, 32'(d_in_ready[0]), 32'd1);

        // Back-to-back flow, one-cycle latency
        t2_vals = '{16'h000A, 16'h000B, 16'h000C};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = t2_vals[i];
            next();
            chk("t2_out_data",  0, 32'(d_out_data[0]),  32'(t2_vals[i]));
            chk("t2_out_valid", 0, 32'(d_out_valid[0]), 32'd1);
            chk("t2_in_ready",  0, 32'(d_in_ready[0]),  32'd1);
        end
        in_valid = 1'b0;
        next();
        chk("t2_drain", 0, 32'(d_out_valid[0]), 32'd0);

        // Fill to full, then drain in order
        apply_reset();
        in_valid = 1'b1;
        in_data  = 16'h0011;
        next();
        chk("t3_count1", 0, 32'(d_count[0]), 32'd1);
        in_data = 16'h0022;
        next();
        chk("t3_count2", 0, 32'(d_count[0]),    32'd2);
        chk("t3_full",   0, 32'(d_in_ready[0]), 32'd0);
        in_data = 16'h0033;
        next();
        chk("t3_held_cnt",  0, 32'(d_count[0]),    32'd2);
        chk("t3_head_11",   0, 32'(d_out_data[0]), 32'h11);
        out_ready = 1'b1;
        next();
        chk("t3_head_22", 0, 32'(d_out_data[0]), 32'h22);
        chk("t3_cnt_dr",  0, 32'(d_count[0]),    32'd1);
        next();
        chk("t3_head_33", 0, 32'(d_out_data[0]), 32'h33);
        in_valid = 1'b0;
        next();
        chk("t3_empty", 0, 32'(d_out_valid[0]), 32'd0);

        // Flush while full, with a same-cycle push
        apply_reset();
        in_valid = 1'b1;
        in_data  = 16'h0001;
        next();
        in_data = 16'h0002;
        next();
        chk("t4_count2", 0, 32'(d_count[0]), 32'd2);
        flush   = 1'b1;
        in_data = 16'h0055;
        next();
        chk("t4_count0",  0, 32'(d_count[0]),     32'd0);
        chk("t4_ovalid0", 0, 32'(d_out_valid[0]), 32'd0);
        chk("t4_iready1", 0, 32'(d_in_ready[0]),  32'd1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        next();
        chk("t4_no55_v", 0, 32'(d_out_valid[0]), 32'd0);
        chk("t4_no55_d", 0, 32'(d_out_data[0]),  32'd0);

`ifdef PIPE_STAGE_PERF_EN
        // Stall counting and saturation
        apply_reset();
        in_valid = 1'b1;
        in_data  = 16'h0001;
        next();
        in_data = 16'h0002;
        next();
        in_data = 16'h0003;
        repeat (5) next();
        chk("t6_stall5", 0, 32'(st0), 32'd5);
        repeat (15) next();
        chk("t6_stall20", 0, 32'(st0), 32'd20);
        chk("t6_sat15",   1, 32'(st1), 32'd15);
        in_valid = 1'b0;
        next();
`endif

        // Randomized traffic, including flushes and occasional resets
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            pct = (c / 500) % 3 == 0 ? 85 : ((c / 500) % 3 == 1 ? 50 : 20);
            reset = ($urandom_range(0, 999) < 3);
            flush = ($urandom_range(0, 99) < 4);
            out_ready = ($urandom_range(0, 99) < pct);
            if (!prev_stalled) begin
                in_valid = ($urandom_range(0, 99) < 70);
                in_data  = 16'($urandom);
            end
            next();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
